channel_mixer: RTL and testbench

Sums the per-channel sample outputs of the synthesizer channels into one mono sample for the audio output path. It sits directly downstream of the channel stage and upstream of the audio sink / sample consumer. On each sample strobe it latches every channel's sample and the channel-enable mask. It then accumulates the enabled channels sequentially, one channel per clock, scales the sum, and presents a registered output sample with a one-cycle valid strobe.

---
 rtl/channel_mixer.sv | 125 ++++++++++++
 tb/tb_channel_mixer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/channel_mixer.sv
// channel_mixer: sums the enabled synthesizer channels into one mono sample.
// Each sample strobe latches all channel samples and the enable mask. The
// enabled channels are then accumulated one per clock, and the scaled sum is
// presented as a registered output with a one-cycle valid strobe.
// Optional build macro: MIXER_SATURATE_EN selects louder mixing that uses a
// smaller shift and clips to full scale. Without it, the full-headroom
// average is used.
module channel_mixer #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 9,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_sample_valid,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_samples,
  input  logic [NUM_CHANNELS-1:0]              i_mixer,
  output logic                                 o_sample_valid,
  output logic [OUT_WIDTH-1:0]                 o_sample,
  output logic                                 o_busy,
  output logic                                 o_overrun
);

  localparam int IDX_W = $clog2(NUM_CHANNELS);
  localparam int ACC_W = SAMPLE_WIDTH + IDX_W;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                                state, state_next;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]  samples_p0;
  logic [NUM_CHANNELS-1:0]               mask_p0;
  logic [ACC_W-1:0]                      acc_p1;
  logic [IDX_W-1:0]                      idx_p1;
  logic [SAMPLE_WIDTH-1:0]               cur_sample;
  logic [ACC_W-1:0]                      term;
  logic [ACC_W-1:0]                      acc_sum;
  logic                                  last;

`ifdef MIXER_SATURATE_EN
  // Louder mix: drop only the bits that exceed the output width, then clip.
  function automatic logic [OUT_WIDTH-1:0] scale_sum(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] shifted;
    logic [ACC_W-1:0] limit;
    shifted = sum >> (SAMPLE_WIDTH - OUT_WIDTH);
    limit   = ACC_W'((1 << OUT_WIDTH) - 1);
    if (shifted > limit)
      return limit[OUT_WIDTH-1:0];
    return shifted[OUT_WIDTH-1:0];
  endfunction
`else
  // Full-headroom average: the worst-case sum maps exactly onto full scale.
  function automatic logic [OUT_WIDTH-1:0] scale_sum(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] shifted;
    shifted = sum >> (ACC_W - OUT_WIDTH);
    return shifted[OUT_WIDTH-1:0];
  endfunction
`endif

  // Current term from the latched copies; disabled channels contribute zero.
  always_comb begin
    cur_sample = samples_p0[idx_p1*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    term       = '0;
    if (mask_p0[idx_p1])
      term = {{IDX_W{1'b0}}, cur_sample};
    acc_sum = acc_p1 + term;
    last    = (idx_p1 == IDX_W'(NUM_CHANNELS - 1));
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: accept a strobe in IDLE, leave ACCUM after the last channel.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_sample_valid) state_next = ACCUM;
      ACCUM:   if (last)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Input capture: snapshot samples and mask so later input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_sample_valid) begin
      samples_p0 <= i_samples;
      mask_p0    <= i_mixer;
    end
  end

  // Accumulation, output register and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_p1         <= '0;
      idx_p1         <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      o_overrun      <= 1'b0;
      if (state == IDLE) begin
        if (i_sample_valid) begin
          acc_p1 <= '0;
          idx_p1 <= '0;
        end
      end else begin
        acc_p1    <= acc_sum;
        idx_p1    <= idx_p1 + 1'b1;
        o_overrun <= i_sample_valid;
        if (last) begin
          o_sample       <= scale_sum(acc_sum);
          o_sample_valid <= 1'b1;
        end
      end
    end
  end

  assign o_busy = (state == ACCUM);

endmodule

// File: tb/tb_channel_mixer.sv
// Directed testbench for channel_mixer at the default parameters.
// Expected values are hand-computed for either build (MIXER_SATURATE_EN).
module tb_channel_mixer;

  logic        clk;
  logic        rst_n;
  logic        sample_valid;
  logic [35:0] samples;
  logic [3:0]  mixer;
  logic        out_valid;
  logic [7:0]  out_sample;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

`ifdef MIXER_SATURATE_EN
  localparam int EXP_ALL   = 255;  // 1000>>1 = 500, clipped
  localparam int EXP_0101  = 200;  // 400>>1
  localparam int EXP_MAX   = 255;  // 2044>>1 = 1022, clipped
`else
  localparam int EXP_ALL   = 125;  // 1000>>3
  localparam int EXP_0101  = 50;   // 400>>3
  localparam int EXP_MAX   = 255;  // 2044>>3
`endif

  channel_mixer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample_valid (sample_valid),
    .i_samples      (samples),
    .i_mixer        (mixer),
    .o_sample_valid (out_valid),
    .o_sample       (out_sample),
    .o_busy         (busy),
    .o_overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] pack(input int s0, input int s1, input int s2, input int s3);
    logic [8:0] a, b, c, d;
    a = 9'(s0); b = 9'(s1); c = 9'(s2); d = 9'(s3);
    return {d, c, b, a};
  endfunction

  // Strobe in the current cycle T, check busy T+1..T+4 and the result at T+5.
  task automatic run_mix(input string tag, input logic [35:0] s, input logic [3:0] m, input int exp);
    samples      = s;
    mixer        = m;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_novld"}, out_valid, 0);
      tick();
    end
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_sample"}, out_sample, exp);
    check({tag, "_idle"}, busy, 0);
    tick();
    check({tag, "_vld_once"}, out_valid, 0);
    check({tag, "_hold"}, out_sample, exp);
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    samples      = '0;
    mixer        = '0;
    tick();
    tick();
    check("rst_vld", out_valid, 0);
    check("rst_sample", out_sample, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;

    // Strobe in the first cycle after reset release.
    run_mix("all4", pack(100, 200, 300, 400), 4'b1111, EXP_ALL);
    run_mix("m0101", pack(100, 200, 300, 400), 4'b0101, EXP_0101);
    run_mix("max", pack(511, 511, 511, 511), 4'b1111, EXP_MAX);
    run_mix("zero", pack(511, 511, 511, 511), 4'b0000, 0);

    // Overrun: strobe at T, dropped strobe at T+2, accepted strobe at T+5.
    samples = pack(100, 200, 300, 400); mixer = 4'b1111; sample_valid = 1'b1;
    tick();  // T+1
    sample_valid = 1'b0;
    check("ovr_quiet", overrun, 0);
    tick();  // T+2
    samples = pack(0, 0, 0, 0); mixer = 4'b0000; sample_valid = 1'b1;
    tick();  // T+3
    sample_valid = 1'b0;
    check("ovr_pulse", overrun, 1);
    tick();  // T+4
    check("ovr_once", overrun, 0);
    check("ovr_novld", out_valid, 0);
    tick();  // T+5
    check("ovr_vld", out_valid, 1);
    check("ovr_first", out_sample, EXP_ALL);
    samples = pack(100, 200, 300, 400); mixer = 4'b0101; sample_valid = 1'b1;
    tick();  // T+6
    sample_valid = 1'b0;
    check("b2b_novld", out_valid, 0);
    check("b2b_busy", busy, 1);
    tick(); tick(); tick();
    check("b2b_pre", out_valid, 0);
    tick();  // T+10
    check("b2b_vld", out_valid, 1);
    check("b2b_sample", out_sample, EXP_0101);
    tick();

    // Input changes during ACCUM must not affect the result.
    samples = pack(100, 200, 300, 400); mixer = 4'b0101; sample_valid = 1'b1;
    tick();  // T+1
    sample_valid = 1'b0;
    tick();  // T+2
    samples = pack(511, 511, 511, 511); mixer = 4'b1111;
    tick(); tick(); tick();  // T+5
    check("latch_vld", out_valid, 1);
    check("latch_sample", out_sample, EXP_0101);
    tick();

    // Reset mid-ACCUM discards the operation.
    samples = pack(100, 200, 300, 400); mixer = 4'b1111; sample_valid = 1'b1;
    tick();  // T+1
    sample_valid = 1'b0;
    tick();  // T+2
    check("mid_busy", busy, 1);
    tick();  // T+3
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sample", out_sample, 0);
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_ovr", overrun, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("post_rst_novld", out_valid, 0);
      tick();
    end
    run_mix("after_rst", pack(100, 200, 300, 400), 4'b1111, EXP_ALL);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
